// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP window scheduler and compare core.
package lbp_pkg;

  localparam int IMG_W_DEF  = 128;
  localparam int ADDR_W_DEF = 14;

  localparam logic [7:0] BORDER_VAL = 8'h00;

  typedef enum logic [3:0] {
    IDLE, TOP, LEFT, PRIME, WRITE, SHIFT, RIGHT, BOTTOM, DONE
  } state_t;

  // 3x3 window, indexed [row k][col j]; [1][1] is the centre pixel
  typedef logic [2:0][2:0][7:0] win_t;

  // Window position of the neighbour feeding each code bit
  localparam int NB_ROW [8] = '{0, 0, 0, 1, 1, 2, 2, 2};
  localparam int NB_COL [8] = '{0, 1, 2, 0, 2, 0, 1, 2};

endpackage

// File: rtl/lbp_core.sv
// Combinational LBP compare: 3x3 window in, 8-bit code out.
module lbp_core
  import lbp_pkg::*;
(
  input  win_t       win,
  output logic [7:0] code
);

  // Each bit is set when its neighbour is >= the centre (unsigned)
  always_comb begin
    code = '0;
    for (int b = 0; b < 8; b++)
      code[b] = (win[NB_ROW[b]][NB_COL[b]] >= win[1][1]);
  end

endmodule

// File: rtl/lbp_window_sched.sv
// Raster-scan LBP scheduler: streams gray pixels through a sliding 3x3
// window with column reuse and writes one code per frame address.
// Build option LBP_SKIP_BORDER_EN drops all border writes (result memory
// is expected to be pre-zeroed).
module lbp_window_sched
  import lbp_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [7:0]        gray_data,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  localparam int            LW   = ADDR_W / 2;
  localparam logic [LW-1:0] ZERO = '0;
  localparam logic [LW-1:0] ONE  = LW'(1);
  localparam logic [LW-1:0] LAST = LW'(IMG_W - 1);
  localparam logic [LW-1:0] PEN  = LW'(IMG_W - 2);

`ifdef LBP_SKIP_BORDER_EN
  localparam bit SKIP_BORDER = 1'b1;
`else
  localparam bit SKIP_BORDER = 1'b0;
`endif

  state_t        state_q, state_d;
  logic [LW-1:0] row_q, col_q;   // centre row/col of the window
  logic [1:0]    k_q, j_q;       // fetch row offset / column within window
  win_t          win_q;
  logic [7:0]    code;
  logic [LW-1:0] f_row, f_col;
  logic          fetch_last;

  lbp_core u_core (.win(win_q), .code(code));

  // Fetch coordinates: PRIME walks columns 0..2, SHIFT loads column c+1
  always_comb begin
    f_row      = row_q + LW'(k_q) - ONE;
    f_col      = (state_q == SHIFT) ? col_q + ONE : LW'(j_q);
    fetch_last = (k_q == 2'd2) && ((state_q == SHIFT) || (j_q == 2'd2));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and all port outputs (every output decodes from state)
  always_comb begin
    state_d   = state_q;
    gray_req  = 1'b0;
    gray_addr = '0;
    lbp_valid = 1'b0;
    lbp_addr  = '0;
    lbp_data  = 8'h00;
    finish    = 1'b0;
    case (state_q)
      IDLE:   if (gray_ready) state_d = SKIP_BORDER ? PRIME : TOP;
      TOP: begin
        lbp_valid = 1'b1;
        lbp_addr  = {ZERO, col_q};
        lbp_data  = BORDER_VAL;
        if (col_q == LAST) state_d = LEFT;
      end
      LEFT: begin
        lbp_valid = 1'b1;
        lbp_addr  = {row_q, ZERO};
        lbp_data  = BORDER_VAL;
        state_d   = PRIME;
      end
      PRIME, SHIFT: begin
        gray_req  = gray_ready;
        gray_addr = {f_row, f_col};
        if (gray_ready && fetch_last) state_d = WRITE;
      end
      WRITE: begin
        lbp_valid = 1'b1;
        lbp_addr  = {row_q, col_q};
        lbp_data  = code;
        if (col_q != PEN)      state_d = SHIFT;
        else if (!SKIP_BORDER) state_d = RIGHT;
        else if (row_q == PEN) state_d = DONE;
        else                   state_d = PRIME;
      end
      RIGHT: begin
        lbp_valid = 1'b1;
        lbp_addr  = {row_q, LAST};
        lbp_data  = BORDER_VAL;
        state_d   = (row_q == PEN) ? BOTTOM : LEFT;
      end
      BOTTOM: begin
        lbp_valid = 1'b1;
        lbp_addr  = {LAST, col_q};
        lbp_data  = BORDER_VAL;
        if (col_q == LAST) state_d = DONE;
      end
      DONE:    finish  = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // Counters and window; the window slides left on leaving WRITE for SHIFT
  always_ff @(posedge clk) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
      k_q   <= '0;
      j_q   <= '0;
      win_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (gray_ready) begin
          row_q <= ONE;
          col_q <= SKIP_BORDER ? ONE : ZERO;
        end
        TOP:  col_q <= col_q + ONE;
        LEFT: col_q <= ONE;
        PRIME: if (gray_ready) begin
          win_q[k_q][j_q] <= gray_data;
          if (k_q == 2'd2) begin
            k_q <= 2'd0;
            j_q <= (j_q == 2'd2) ? 2'd0 : j_q + 2'd1;
          end else begin
            k_q <= k_q + 2'd1;
          end
        end
        WRITE: begin
          if (col_q != PEN) begin
            col_q <= col_q + ONE;
            for (int k = 0; k < 3; k++) begin
              win_q[k][0] <= win_q[k][1];
              win_q[k][1] <= win_q[k][2];
            end
          end else if (SKIP_BORDER) begin
            row_q <= row_q + ONE;
            col_q <= ONE;
          end
        end
        SHIFT: if (gray_ready) begin
          win_q[k_q][2] <= gray_data;
          k_q <= (k_q == 2'd2) ? 2'd0 : k_q + 2'd1;
        end
        RIGHT: begin
          if (row_q != PEN) row_q <= row_q + ONE;
          else              col_q <= ZERO;
        end
        BOTTOM:  col_q <= col_q + ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_window_sched.sv
// Self-checking bench for lbp_window_sched on a 16x16 frame.
`timescale 1ns/1ps
module tb_lbp_window_sched;

  localparam int W    = 16;
  localparam int AW   = 8;
  localparam int N    = W * W;
  localparam int MAXC = 4000;
`ifdef LBP_SKIP_BORDER_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct { int pat; int r; int c; logic [7:0] exp; } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          gray_ready = 1'b0;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [7:0]    gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;
  logic          finish;

  logic [7:0] img  [N];
  logic [7:0] res  [N];
  logic [7:0] snap [N];
  int         wcnt [N];
  bit         rdy_pat [MAXC + 64];
  int         tests, fails, req_viol, nwrites, last_wr, cyc, fin;
  vec_t       tbl [$];

  lbp_window_sched #(.IMG_W(W), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(gray_req),
    .gray_addr(gray_addr), .gray_data(gray_data), .lbp_valid(lbp_valid),
    .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish)
  );

  always #5 clk = ~clk;

  // Gray memory answers combinationally in the request cycle
  assign gray_data = img[gray_addr];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, sample outputs, log writes
  task automatic step(input bit rdy, input bit rst_n);
    @(negedge clk);
    gray_ready = rdy;
    reset      = rst_n;
    #1;
    if (gray_req && !gray_ready) req_viol++;
    if (lbp_valid) begin
      res[lbp_addr] = lbp_data;
      wcnt[lbp_addr]++;
      nwrites++;
      last_wr = cyc;
    end
  endtask

  task automatic do_reset(input string name);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check({name, " outputs zero"},
          int'({gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish}), 0);
    step(1'b0, 1'b1);
  endtask

  // Reference LBP from the raw image
  function automatic logic [7:0] ref_code(input int r, input int c);
    int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    logic [7:0] v;
    v = 8'h00;
    if (r == 0 || c == 0 || r == W-1 || c == W-1) return 8'h00;
    for (int k = 0; k < 8; k++)
      v[k] = (img[(r + dr[k]) * W + c + dc[k]] >= img[r * W + c]);
    return v;
  endfunction

  // Cycle cost of a fetch burst of n reads starting at cycle t
  function automatic int fetch_end(input int t, input int n, input bit stall);
    int tt, left;
    tt = t;
    left = n;
    while (left > 0 && tt < MAXC) begin
      if (!stall || rdy_pat[tt]) left--;
      tt++;
    end
    return tt;
  endfunction

  // First cycle in which finish is high; cycle 0 is the IDLE exit cycle
  function automatic int model_end(input bit stall);
    int t;
    t = 1;
    if (!SKIP) t += W;
    for (int r = 1; r < W-1; r++) begin
      if (!SKIP) t += 1;
      t = fetch_end(t, 9, stall) + 1;
      for (int c = 2; c <= W-2; c++) t = fetch_end(t, 3, stall) + 1;
      if (!SKIP) t += 1;
    end
    if (!SKIP) t += W;
    return t;
  endfunction

  task automatic set_img(input int p);
    for (int a = 0; a < N; a++)
      case (p)
        0:       img[a] = 8'h55;
        1:       img[a] = 8'(a % W);
        2:       img[a] = 8'h00;
        default: img[a] = 8'($urandom_range(0, 15) * 16);
      endcase
    if (p == 2) img[5 * W + 5] = 8'hFF;
  endtask

  task automatic run_frame(input bit stall, input int abort_at, output int f);
    for (int a = 0; a < N; a++) begin res[a] = 8'h00; wcnt[a] = 0; end
    nwrites = 0; req_viol = 0; last_wr = -1; f = -1;
    for (int i = 0; i < MAXC; i++) begin
      cyc = i;
      step(stall ? rdy_pat[i] : 1'b1, 1'b1);
      if (finish) begin f = i; break; end
      if (abort_at > 0 && i == abort_at) break;
    end
  endtask

  task automatic check_frame(input string name, input bit stall, input int f);
    int bad, first, badw, expw;
    bad = 0; first = -1; badw = 0;
    for (int a = 0; a < N; a++) begin
      if (res[a] != ref_code(a / W, a % W)) begin
        bad++;
        if (first < 0) first = a;
      end
      expw = (SKIP && (a / W == 0 || a % W == 0 || a / W == W-1 || a % W == W-1)) ? 0 : 1;
      if (wcnt[a] != expw) badw++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s data: %0d pixels wrong, first (%0d,%0d) got 0x%0h expected 0x%0h",
               name, bad, first / W, first % W, res[first], ref_code(first / W, first % W));
    end
    check({name, " write-once map"}, badw, 0);
    check({name, " write total"}, nwrites, SKIP ? (W-2) * (W-2) : N);
    check({name, " finish cycle"}, f, model_end(stall));
    check({name, " finish after last write"}, last_wr, f - 1);
    check({name, " req while not ready"}, req_viol, 0);
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    tbl.push_back('{0, 1, 1, 8'hFF});
    tbl.push_back('{0, 8, 8, 8'hFF});
    tbl.push_back('{0, 14, 14, 8'hFF});
    tbl.push_back('{0, 0, 3, 8'h00});
    tbl.push_back('{0, 15, 9, 8'h00});
    tbl.push_back('{1, 3, 7, 8'hD6});
    tbl.push_back('{1, 1, 1, 8'hD6});
    tbl.push_back('{1, 14, 14, 8'hD6});
    tbl.push_back('{1, 7, 0, 8'h00});
    tbl.push_back('{1, 7, 15, 8'h00});
    tbl.push_back('{2, 5, 5, 8'h00});
    tbl.push_back('{2, 4, 4, 8'hFF});
    tbl.push_back('{2, 6, 6, 8'hFF});
    tbl.push_back('{2, 4, 5, 8'hFF});
    for (int i = 0; i < MAXC + 64; i++) rdy_pat[i] = 1'($urandom_range(0, 1));
    rdy_pat[0] = 1'b1;

    do_reset("power-on reset");

    // Fixed and random images, uninterrupted
    for (int p = 0; p < 4; p++) begin
      set_img(p);
      run_frame(1'b0, 0, fin);
      check_frame($sformatf("pattern %0d", p), 1'b0, fin);
      foreach (tbl[t])
        if (tbl[t].pat == p)
          check($sformatf("vec p%0d (%0d,%0d)", p, tbl[t].r, tbl[t].c),
                int'(res[tbl[t].r * W + tbl[t].c]), int'(tbl[t].exp));
      if (p != 3) do_reset($sformatf("reset after pattern %0d", p));
    end
    for (int a = 0; a < N; a++) snap[a] = res[a];

    // Same random image with random gray_ready stalls
    do_reset("reset before stall run");
    run_frame(1'b1, 0, fin);
    check_frame("stalled", 1'b1, fin);
    begin
      int diff;
      diff = 0;
      for (int a = 0; a < N; a++) if (res[a] != snap[a]) diff++;
      check("stalled vs uninterrupted", diff, 0);
    end

    // Reset in the middle of a frame, then a full clean rerun
    do_reset("reset before abort run");
    run_frame(1'b0, 400, fin);
    check("aborted run not finished", fin, -1);
    do_reset("mid-frame reset");
    run_frame(1'b0, 0, fin);
    check_frame("after mid-frame reset", 1'b0, fin);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
